// File: rtl/ofmap_pkg.sv
// Shared widths, FSM state type and requantisation helpers for the ofmap quantizer.
package ofmap_pkg;

  localparam int unsigned PSUM_WIDTH  = 32;
  localparam int unsigned OUT_WIDTH   = 8;
  localparam int unsigned SHIFT_WIDTH = 5;
  localparam int unsigned DEF_PE_SIZE = 14;
  localparam int unsigned DEF_OC      = 64;

  localparam logic signed [PSUM_WIDTH:0] SAT_MAX = (PSUM_WIDTH+1)'((1 << (OUT_WIDTH-1)) - 1);
  localparam logic signed [PSUM_WIDTH:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Round-half-up arithmetic shift; one guard bit keeps the bias add from wrapping.
  function automatic logic signed [PSUM_WIDTH:0] round_shift(
    input logic signed [PSUM_WIDTH-1:0]  psum,
    input logic        [SHIFT_WIDTH-1:0] shift
  );
    logic signed [PSUM_WIDTH:0] ext;
    logic signed [PSUM_WIDTH:0] bias;
    ext  = {psum[PSUM_WIDTH-1], psum};
    bias = {{PSUM_WIDTH{1'b0}}, 1'b1} << (shift - 1'b1);
    if (shift == '0) begin
      return ext;
    end
    return (ext + bias) >>> shift;
  endfunction

  // Optional ReLU followed by signed saturation to the output width.
  function automatic logic signed [OUT_WIDTH-1:0] saturate(
    input logic signed [PSUM_WIDTH:0] r,
    input logic                       relu
  );
    if (relu && (r < 0)) begin
      return '0;
    end
    if (r > SAT_MAX) begin
      return SAT_MAX[OUT_WIDTH-1:0];
    end
    if (r < SAT_MIN) begin
      return SAT_MIN[OUT_WIDTH-1:0];
    end
    return r[OUT_WIDTH-1:0];
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] requant(
    input logic signed [PSUM_WIDTH-1:0]  psum,
    input logic        [SHIFT_WIDTH-1:0] shift,
    input logic                          relu
  );
    return saturate(round_shift(psum, shift), relu);
  endfunction

endpackage

// File: rtl/ofmap_quantizer_lane.sv
// One lane: stage 1 rounds/shifts, stage 2 applies ReLU/saturation; valid rides alongside.
module quant_lane
  import ofmap_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_i,
  input  logic signed [PSUM_WIDTH-1:0]  psum_i,
  input  logic        [SHIFT_WIDTH-1:0] shift_i,
  input  logic                          relu_i,
  output logic                          en_o,
  output logic        [OUT_WIDTH-1:0]   data_o
);

  logic                        v1_q;
  logic signed [PSUM_WIDTH:0]  r1_q;
  logic signed [PSUM_WIDTH:0]  r1_d;
  logic                        en_q;
  logic signed [OUT_WIDTH-1:0] data_q;
  logic signed [OUT_WIDTH-1:0] data_d;

  // Combinational datapath for both stages.
  always_comb begin
    r1_d   = round_shift(psum_i, shift_i);
    data_d = saturate(r1_q, relu_i);
  end

  // Stage 1: capture rounded/shifted value; holds when no valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      r1_q <= '0;
    end else begin
      v1_q <= valid_i;
      if (valid_i) begin
        r1_q <= r1_d;
      end
    end
  end

  // Stage 2: capture saturated output; data holds while enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q   <= 1'b0;
      data_q <= '0;
    end else begin
      en_q <= v1_q;
      if (v1_q) begin
        data_q <= data_d;
      end
    end
  end

  assign en_o   = en_q;
  assign data_o = data_q;

endmodule

// File: rtl/ofmap_quantizer.sv
// Tile-level control for the per-lane requantisation pipelines: FSM, valid masking,
// per-lane accept/output counters and sticky error flag.
module ofmap_quantizer
  import ofmap_pkg::*;
#(
  parameter int unsigned PE_SIZE = DEF_PE_SIZE,
  parameter int unsigned OC      = DEF_OC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic                          relu_en_i,
  input  logic [PE_SIZE-1:0]            psum_valid_i,
  input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
  output logic [PE_SIZE-1:0]            ofmap_en_o,
  output logic [OUT_WIDTH*PE_SIZE-1:0]  ofmap_row_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  localparam int unsigned CNT_W = $clog2(OC);
  localparam int unsigned ACC_W = CNT_W + 1;

  state_e                 state_q, state_d;
  logic [SHIFT_WIDTH-1:0] shift_q;
  logic                   relu_q;
  logic                   err_q, err_d;
  logic                   start_tile;
  logic                   last_out;
  logic [PE_SIZE-1:0]     accept;
  logic [PE_SIZE-1:0]     overrun;
  logic [PE_SIZE-1:0]     en;
  logic [CNT_W-1:0]       out_cnt_q [PE_SIZE];
  logic [ACC_W-1:0]       acc_cnt_q [PE_SIZE];

  // Valid masking: accept only in RUN and only until a lane has taken OC values.
  always_comb begin
    accept  = '0;
    overrun = '0;
    for (int unsigned i = 0; i < PE_SIZE; i++) begin
      if ((state_q == RUN) && psum_valid_i[i]) begin
        if (acc_cnt_q[i] == ACC_W'(OC)) begin
          overrun[i] = 1'b1;
        end else begin
          accept[i] = 1'b1;
        end
      end
    end
  end

  assign start_tile = (state_q == IDLE) && start_i;
  assign last_out   = en[PE_SIZE-1] && (out_cnt_q[PE_SIZE-1] == CNT_W'(OC - 1));

  // Next-state and error logic; a start in IDLE overrides any same-cycle error.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)  state_d = RUN;
      RUN:     if (last_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    err_d = err_q | (|overrun) | ((state_q != RUN) && (|psum_valid_i));
    if (start_tile) begin
      err_d = 1'b0;
    end
  end

  // FSM state, tile parameters and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      relu_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (start_tile) begin
        shift_q <= shift_i;
        relu_q  <= relu_en_i;
      end
    end
  end

  // Per-lane accept and output counters, cleared at tile start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PE_SIZE; i++) begin
        out_cnt_q[i] <= '0;
        acc_cnt_q[i] <= '0;
      end
    end else if (start_tile) begin
      for (int unsigned i = 0; i < PE_SIZE; i++) begin
        out_cnt_q[i] <= '0;
        acc_cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < PE_SIZE; i++) begin
        if (accept[i]) acc_cnt_q[i] <= acc_cnt_q[i] + 1'b1;
        if (en[i])     out_cnt_q[i] <= out_cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < PE_SIZE; g++) begin : g_lane
    quant_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .valid_i (accept[g]),
      .psum_i  (psum_row_i[g*PSUM_WIDTH +: PSUM_WIDTH]),
      .shift_i (shift_q),
      .relu_i  (relu_q),
      .en_o    (en[g]),
      .data_o  (ofmap_row_o[g*OUT_WIDTH +: OUT_WIDTH])
    );
  end

  assign ofmap_en_o = en;
  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);
  assign err_o      = err_q;

endmodule

// File: tb/tb_ofmap_quantizer.sv
// Directed bench for ofmap_quantizer with hand-computed expected values.
module tb_ofmap_quantizer;

  localparam int unsigned PE  = 14;
  localparam int unsigned PW  = 32;
  localparam int unsigned OW  = 8;
  localparam int unsigned OCN = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [4:0]        shift;
  logic              relu;
  logic [PE-1:0]     valid;
  logic [PE*PW-1:0]  psum;
  logic [PE-1:0]     ofmap_en;
  logic [PE*OW-1:0]  ofmap_row;
  logic              busy;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;
  int vp[PE];
  int ve[PE];

  ofmap_quantizer #(.PE_SIZE(PE), .OC(OCN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .shift_i      (shift),
    .relu_en_i    (relu),
    .psum_valid_i (valid),
    .psum_row_i   (psum),
    .ofmap_en_o   (ofmap_en),
    .ofmap_row_o  (ofmap_row),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lane_out(input int i);
    logic [OW-1:0] v;
    v = ofmap_row[i*OW +: OW];
    return int'($signed(v));
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    valid = '0;
    psum  = '0;
    shift = '0;
    relu  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Start a tile with the given shift/relu, push one beat of vp[] on all lanes, check ve[].
  task automatic beat(input string tag, input int sh, input bit rl);
    do_reset();
    start = 1'b1;
    shift = 5'(sh);
    relu  = rl;
    step();
    start = 1'b0;
    shift = ~5'(sh);
    relu  = ~rl;
    check({tag, "_busy"}, int'(busy), 1);
    for (int i = 0; i < PE; i++) psum[i*PW +: PW] = 32'(vp[i]);
    valid = '1;
    step();
    valid = '0;
    psum  = '0;
    check({tag, "_en_lat1"}, int'(ofmap_en), 0);
    step();
    check({tag, "_en"}, int'(ofmap_en), (1 << PE) - 1);
    for (int i = 0; i < PE; i++) check($sformatf("%s_lane%0d", tag, i), lane_out(i), ve[i]);
    check({tag, "_err"}, int'(err), 0);
    step();
    check({tag, "_en_off"}, int'(ofmap_en), 0);
    check({tag, "_hold"}, lane_out(0), ve[0]);
  endtask

  // Full tile, lane i starts skew*i cycles after lane 0; value k on lane i is k-32+i.
  task automatic run_tile(input string tag, input int skew);
    int nseen[PE];
    int done_cnt;
    int done_at;
    int last;
    int k;
    last     = OCN - 1 + (PE - 1) * skew;
    done_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < PE; i++) nseen[i] = 0;
    start = 1'b1;
    shift = '0;
    relu  = 1'b0;
    step();
    start = 1'b0;
    for (int s = 0; s <= last + 5; s++) begin
      for (int i = 0; i < PE; i++) begin
        k = s - i * skew;
        valid[i] = (k >= 0) && (k < OCN);
        psum[i*PW +: PW] = 32'(k - 32 + i);
      end
      step();
      for (int i = 0; i < PE; i++) begin
        if (ofmap_en[i]) begin
          check({tag, "_data"}, lane_out(i), nseen[i] - 32 + i);
          nseen[i]++;
        end
      end
      if (done) begin
        done_cnt++;
        done_at = s;
      end
    end
    valid = '0;
    for (int i = 0; i < PE; i++) check($sformatf("%s_count%0d", tag, i), nseen[i], OCN);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_at"}, done_at, last + 2);
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    int n_en;
    int n_bad;

    do_reset();
    check("rst_en",   int'(ofmap_en), 0);
    check("rst_row",  int'(ofmap_row == '0), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err",  int'(err), 0);

    // No shift, no relu: pass-through and saturation boundaries.
    vp = '{100, 1000, -1000, -5, 127, 128, -128, -129, 0, 1, -1, 32'h7fffffff, 32'h80000000, 42};
    ve = '{100, 127, -128, -5, 127, 127, -128, -128, 0, 1, -1, 127, -128, 42};
    beat("s0", 0, 1'b0);

    // Shift 4, rounding half up; extreme values must not wrap on the bias add.
    vp = '{40, -40, 8, 7, -8, -9, 32'h7fffffff, 32'h80000000, 24, -24, 2024, 2040, -2056, 0};
    ve = '{3, -2, 1, 0, 0, -1, 127, -128, 2, -1, 127, 127, -128, 0};
    beat("s4", 4, 1'b0);

    // Shift 4 with relu.
    vp = '{40, -40, 8, -9, 7, -1000, 32'h7fffffff, 32'h80000000, 24, -24, 2040, -8, 0, 1000};
    ve = '{3, 0, 1, 0, 0, 0, 127, 0, 2, 0, 127, 0, 0, 63};
    beat("s4r", 4, 1'b1);

    // Shift 1: smallest rounding step.
    vp = '{3, -3, 1, -1, 2, -2, 255, 256, -256, -257, 5, -5, 0, 254};
    ve = '{2, -1, 1, 0, 1, -1, 127, 127, -128, -128, 3, -2, 0, 127};
    beat("s1", 1, 1'b0);

    // Shift 31: maximum shift amount.
    vp = '{32'h40000000, 32'h3fffffff, 32'hc0000000, 32'h7fffffff, 32'h80000000, 32'hbfffffff,
           0, 1, -1, 5, 6, 7, 8, 9};
    ve = '{1, 0, 0, 1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    beat("s31", 31, 1'b0);

    // No shift with relu.
    vp = '{1000, -1000, -1, 0, 127, -128, 200, 5, -200, 64, -64, 1, 32'h7fffffff, 32'h80000000};
    ve = '{127, 0, 0, 0, 127, 0, 127, 5, 0, 64, 0, 1, 127, 0};
    beat("s0r", 0, 1'b1);

    // Valid without start is dropped and flags error; next start clears it.
    do_reset();
    valid[3] = 1'b1;
    psum[3*PW +: PW] = 32'd50;
    step();
    valid = '0;
    step();
    step();
    check("idle_valid_en",  int'(ofmap_en), 0);
    check("idle_valid_err", int'(err), 1);
    check("idle_busy",      int'(busy), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_clr_err",  int'(err), 0);
    check("start_busy",     int'(busy), 1);

    // Start and valid together in IDLE: start wins, valid dropped, no error.
    do_reset();
    start = 1'b1;
    valid = '1;
    step();
    start = 1'b0;
    valid = '0;
    check("start_valid_err", int'(err), 0);
    step();
    step();
    check("start_valid_en", int'(ofmap_en), 0);

    // Overrun: lane 0 offered OC+1 values; the extra one is dropped and flags error.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    n_en = 0;
    for (int s = 0; s < OCN + 3; s++) begin
      valid[0] = (s <= OCN);
      psum[0 +: PW] = 32'(s);
      step();
      if (ofmap_en[0]) n_en++;
      if (s == OCN - 1) check("ovr_err_before", int'(err), 0);
    end
    valid = '0;
    check("ovr_count", n_en, OCN);
    check("ovr_err",   int'(err), 1);
    check("ovr_last",  lane_out(0), OCN - 1);
    check("ovr_busy",  int'(busy), 1);

    // Full skewed tile.
    do_reset();
    run_tile("tile_skew", 1);

    // Reset mid-tile at value 30, then a clean unskewed tile.
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int s = 0; s < 30; s++) begin
      valid = '1;
      for (int i = 0; i < PE; i++) psum[i*PW +: PW] = 32'(s);
      step();
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en",   int'(ofmap_en), 0);
    check("mid_rst_row",  int'(ofmap_row == '0), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_err",  int'(err), 0);
    valid = '0;
    psum  = '0;
    #2 rst = 1'b0;
    n_bad = 0;
    for (int s = 0; s < 4; s++) begin
      step();
      if (done || busy || (ofmap_en != '0)) n_bad++;
    end
    check("post_rst_quiet", n_bad, 0);
    run_tile("tile_flat", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
